mc_processor_top: RTL and testbench
===================================

# mc_processor_top

Multi-cycle, parametrised successor to the single-cycle core top. Executes the existing ISA over several clock cycles, sequenced by an FSM, and reuses the existing `control`, `alu_top`, `reg_bank`, `sgn_extend` and `cond_branch` blocks. Instruction and data memories move outside the core behind req/ack handshakes, so variable-latency memories are supported. Adds a halt state and a retired-instruction counter.

## Interface
- N, 32, datapath/register width
- AW, 10, memory word-address width
- HALT_OP, 6'b111111, opcode that halts the core

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  AW  word address, PC[AW-1:0]
- imem_rdata  in  N  instruction word, valid when imem_ack
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  AW  ALUR[AW-1:0]
- dmem_wdata  out  N  B latch
- dmem_rdata  in  N  load data, valid when dmem_ack
- dmem_ack  in  1  data access complete
- halted  out  1  core is in HALT
- pc_out  out  N  current PC (debug)
- instret  out  32  retired-instruction count

## Operation
- Internal registers:
  - PC (word address; sequential increment is +1)
  - IR
  - A and B operand latches
  - ALUR (ALU result latch)
  - MDR (load data latch)
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - imem_req=1.
  - On imem_ack: IR<=imem_rdata, go to DECODE.
  - Otherwise stay.
- **DECODE**
  - `control` decodes IR; reg_bank reads rs/rt; A and B latch.
  - If IR[31:26]==HALT_OP, go to HALT; PC and instret are not updated.
- **EXEC**
  - ALU operands use the same selects as the single-cycle core: PC replaces A when brOp≠0; B or the sign-extended immediate is chosen by BSel.
  - ALUR latches the ALU result.
  - Branch taken (cond_branch true): PC<=ALU result, retire, go to FETCH.
  - memRd or memWr: go to MEM.
  - regWr (no memory access): go to WB.
  - Otherwise: PC<=PC+1, retire, go to FETCH.
- **MEM**
  - dmem_req=1, dmem_we=memWr.
  - On dmem_ack:
    - Load: MDR<=dmem_rdata, go to WB.
    - Store: PC<=PC+1, retire, go to FETCH.
- **WB**
  - Write-back data mux is identical to the single-cycle core (ALUR/MDR/A/B, including the isMV path).
  - Destination is rd or rt per wrRegSel.
  - PC<=PC+1, retire, go to FETCH.
- **HALT**: absorbing state; no requests issued; halted=1. Only reset leaves HALT.
- Retire means instret<=instret+1. instret wraps modulo 2^32.
- Opcodes with all control signals zero (undefined) execute as NOP.
- Arithmetic is modulo 2^N. Addresses are truncated to AW bits, so memory wraps.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, PC=0, IR=0, instret=0.
  - imem_req=0, dmem_req=0, dmem_we=0, halted=0.
  - Register file contents are not reset.
- First imem_req is asserted in the first cycle after rst deasserts.
- Requests:
  - req is asserted on entry to FETCH or MEM.
  - addr, we and wdata stay stable while req=1.
  - req drops in the cycle after ack is sampled.
  - An ack arriving in the first req cycle (zero wait) is legal.
  - An ack while req=0 is ignored.
- Latency with zero-wait memories:
  - taken branch/jump: 3 cycles
  - ALU op: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each wait cycle without ack adds exactly 1 cycle.
- Reset asserted mid-request drops req combinationally with reset, and the in-flight access is abandoned.
- The register write in WB and the PC update occur on the same clock edge.

## Structure
- Package `mc_cpu_pkg`:
  - state enum (6 states, 3 bits)
  - HALT_OP default
  - ALU/branch opcode constants shared with `control`
- Sub-module `mc_fsm`: state register, next-state logic, req/latch-enable outputs.
- The top holds the datapath latches and instantiates `control`, `alu_top`, `reg_bank`, `sgn_extend` (×2) and `cond_branch`.

## Test plan
- Reset, then a zero-wait ADD with r1=5, r2=7 into r3 → r3=12; instret=1 after 4 cycles; pc_out=1.
- Load with r1=4, offset 2; dmem_ack delayed 3 cycles; memory[6]=0xDEADBEEF → dmem_addr=6 held stable; r5=0xDEADBEEF; instruction takes 8 cycles.
- Store to address 1023+1 → dmem_addr=0 (wrap); dmem_we=1; dmem_wdata=B.
- Taken branch at PC=10, offset −4 → next imem_addr=6; untaken branch → 11; instret +1 either way.
- HALT_OP at PC=3 → halted=1 forever; no further req; instret frozen; pc_out=3.
- rst pulsed low during a pending dmem_req → req=0 immediately; after release PC=0, instret=0, fetch resumes from 0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared types and constants for the multi-cycle core: FSM states, opcodes,
// ALU/branch operation codes and the decoded control word.
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

  // R-type: op rs rt rd; I-type: op rs rt imm16; J-type: op imm26 (PC-relative)
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_MV   = 6'h12;
  localparam logic [5:0] OP_MVT  = 6'h13;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_JMP  = 6'h22;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_JMP  = 2'd3
  } br_op_t;

  typedef enum logic [1:0] {
    BS_REG   = 2'd0,
    BS_IMM16 = 2'd1,
    BS_IMM26 = 2'd2
  } b_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_A   = 2'd2,
    WB_B   = 2'd3
  } wb_sel_t;

  // An all-zero control word is a NOP, which is what undefined opcodes decode to
  typedef struct packed {
    alu_op_t alu_op;
    br_op_t  br_op;
    b_sel_t  b_sel;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_wr;
    logic    wr_reg_sel;
    wb_sel_t wb_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_blocks.sv
// Datapath building blocks shared with the single-cycle core: decoder, ALU,
// register bank, sign extender and branch condition unit.
module control
  import mc_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD:  begin ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_SLT:  begin ctrl.alu_op = ALU_SLT; ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; end
      OP_ADDI: begin ctrl.b_sel = BS_IMM16; ctrl.reg_wr = 1'b1; end
      OP_LW:   begin ctrl.b_sel = BS_IMM16; ctrl.mem_rd = 1'b1; ctrl.reg_wr = 1'b1; ctrl.wb_sel = WB_MEM; end
      OP_SW:   begin ctrl.b_sel = BS_IMM16; ctrl.mem_wr = 1'b1; end
      OP_MV:   begin ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; ctrl.wb_sel = WB_A; end
      OP_MVT:  begin ctrl.reg_wr = 1'b1; ctrl.wr_reg_sel = 1'b1; ctrl.wb_sel = WB_B; end
      OP_BEQ:  begin ctrl.br_op = BR_EQ;  ctrl.b_sel = BS_IMM16; end
      OP_BNE:  begin ctrl.br_op = BR_NE;  ctrl.b_sel = BS_IMM16; end
      OP_JMP:  begin ctrl.br_op = BR_JMP; ctrl.b_sel = BS_IMM26; end
      default: ctrl = '0;
    endcase
  end

endmodule

module alu_top
  import mc_cpu_pkg::*;
#(
  parameter int N = 32
) (
  input  alu_op_t      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
  end

endmodule

module reg_bank #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  input  logic [4:0]   wa,
  input  logic [N-1:0] wd,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2
);

  logic [N-1:0] regs [0:31];

  // r0 reads as zero and is never written; the rest of the bank has no reset
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

module sgn_extend #(
  parameter int IW = 16,
  parameter int OW = 32
) (
  input  logic [IW-1:0] value,
  output logic [OW-1:0] extended
);

  assign extended = {{(OW-IW){value[IW-1]}}, value};

endmodule

module cond_branch
  import mc_cpu_pkg::*;
#(
  parameter int N = 32
) (
  input  br_op_t       br_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         taken
);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_EQ:   taken = (a == b);
      BR_NE:   taken = (a != b);
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_fsm.sv
// Instruction sequencer: state register, next-state logic and the memory
// requests / latch enables that drive the datapath in each phase.
module mc_fsm
  import mc_cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic imem_ack,
  input  logic dmem_ack,
  input  logic is_halt,
  input  logic taken,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic reg_wr,
  output logic imem_req,
  output logic dmem_req,
  output logic ir_en,
  output logic ab_en,
  output logic alur_en,
  output logic mdr_en,
  output logic rf_we,
  output logic pc_load,
  output logic pc_inc,
  output logic retire,
  output logic halted
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (imem_ack) next_state = S_DECODE;
      S_DECODE: next_state = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (taken)                 next_state = S_FETCH;
        else if (mem_rd || mem_wr) next_state = S_MEM;
        else if (reg_wr)           next_state = S_WB;
        else                       next_state = S_FETCH;
      end
      S_MEM:    if (dmem_ack) next_state = mem_rd ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Requests are gated by reset so an in-flight access drops the moment reset asserts
  always_comb begin
    imem_req = rst && (state == S_FETCH);
    dmem_req = rst && (state == S_MEM);
    ir_en    = (state == S_FETCH) && imem_ack;
    ab_en    = (state == S_DECODE);
    alur_en  = (state == S_EXEC);
    mdr_en   = (state == S_MEM) && dmem_ack && mem_rd;
    rf_we    = (state == S_WB);
    pc_load  = (state == S_EXEC) && taken;
    pc_inc   = ((state == S_EXEC) && !taken && !mem_rd && !mem_wr && !reg_wr) ||
               ((state == S_MEM) && dmem_ack && mem_wr) ||
               (state == S_WB);
    retire   = pc_load || pc_inc;
    halted   = (state == S_HALT);
  end

endmodule

// File: rtl/mc_processor_top.sv
// Multi-cycle core top: PC/IR/operand/result latches around the shared
// datapath blocks, with instruction and data memories behind req/ack handshakes.
module mc_processor_top
  import mc_cpu_pkg::*;
#(
  parameter int         N       = 32,
  parameter int         AW      = 10,
  parameter logic [5:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_rdata,
  input  logic          imem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [N-1:0]  dmem_wdata,
  input  logic [N-1:0]  dmem_rdata,
  input  logic          dmem_ack,
  output logic          halted,
  output logic [N-1:0]  pc_out,
  output logic [31:0]   instret
);

  logic [N-1:0] pc, ir, a, b, alur, mdr;
  logic [N-1:0] rd1, rd2, wb_data, alu_a, alu_b, alu_y, imm16_ext, imm26_ext;
  logic [4:0]   wr_addr;
  ctrl_t        ctrl;
  logic         taken, is_halt;
  logic         ir_en, ab_en, alur_en, mdr_en, rf_we, pc_load, pc_inc, retire;

  assign is_halt = (ir[31:26] == HALT_OP);

  control u_control (.opcode(ir[31:26]), .ctrl(ctrl));

  reg_bank #(.N(N)) u_reg_bank (
    .clk(clk), .we(rf_we), .ra1(ir[25:21]), .ra2(ir[20:16]),
    .wa(wr_addr), .wd(wb_data), .rd1(rd1), .rd2(rd2)
  );

  sgn_extend #(.IW(16), .OW(N)) u_sext16 (.value(ir[15:0]), .extended(imm16_ext));
  sgn_extend #(.IW(26), .OW(N)) u_sext26 (.value(ir[25:0]), .extended(imm26_ext));

  // Branches compute their target in the ALU from PC; the condition uses the A/B latches
  assign alu_a = (ctrl.br_op != BR_NONE) ? pc : a;

  always_comb begin
    alu_b = b;
    case (ctrl.b_sel)
      BS_IMM16: alu_b = imm16_ext;
      BS_IMM26: alu_b = imm26_ext;
      default:  alu_b = b;
    endcase
  end

  alu_top #(.N(N)) u_alu (.op(ctrl.alu_op), .a(alu_a), .b(alu_b), .y(alu_y));

  cond_branch #(.N(N)) u_cond (.br_op(ctrl.br_op), .a(a), .b(b), .taken(taken));

  always_comb begin
    wb_data = alur;
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = mdr;
      WB_A:    wb_data = a;
      WB_B:    wb_data = b;
      default: wb_data = alur;
    endcase
  end

  assign wr_addr = ctrl.wr_reg_sel ? ir[15:11] : ir[20:16];

  mc_fsm u_fsm (
    .clk(clk), .rst(rst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .is_halt(is_halt), .taken(taken), .mem_rd(ctrl.mem_rd), .mem_wr(ctrl.mem_wr),
    .reg_wr(ctrl.reg_wr), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_en(ir_en), .ab_en(ab_en), .alur_en(alur_en), .mdr_en(mdr_en),
    .rf_we(rf_we), .pc_load(pc_load), .pc_inc(pc_inc), .retire(retire),
    .halted(halted)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alur    <= '0;
      mdr     <= '0;
      instret <= '0;
    end else begin
      if (ir_en)   ir   <= imem_rdata;
      if (ab_en)   begin a <= rd1; b <= rd2; end
      if (alur_en) alur <= alu_y;
      if (mdr_en)  mdr  <= dmem_rdata;
      if (pc_load)     pc <= alu_y;
      else if (pc_inc) pc <= pc + N'(1);
      if (retire)  instret <= instret + 32'd1;
    end
  end

  // Latched IR/ALUR/B keep address, direction and write data stable for the whole request
  assign imem_addr  = pc[AW-1:0];
  assign dmem_addr  = alur[AW-1:0];
  assign dmem_wdata = b;
  assign dmem_we    = dmem_req && ctrl.mem_wr;
  assign pc_out     = pc;

endmodule

// File: tb/tb_mc_processor_top.sv
// Directed bench for mc_processor_top: small programs run against variable-latency
// instruction/data memory models, with hand-computed results and latencies.
module tb_mc_processor_top;
  import mc_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, pc_out, instret;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem_init [0:1023];
  logic [9:0]  st_addr_log [0:7];
  logic [31:0] st_data_log [0:7];
  int          st_count, iwait, dwait;
  int          imem_lat = 0;
  int          dmem_lat = 0;
  logic        stray_iack = 1'b0;
  logic        stray_dack = 1'b0;
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] HALT_WORD = {6'b111111, 26'd0};

  always #5 clk = ~clk;

  mc_processor_top #(.N(32), .AW(10), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halted(halted), .pc_out(pc_out), .instret(instret)
  );

  assign imem_ack   = (imem_req && (iwait >= imem_lat)) || stray_iack;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = (dmem_req && (dwait >= dmem_lat)) || stray_dack;
  assign dmem_rdata = dmem_init[dmem_addr];

  // Memory models: count wait cycles of an open request and log completed stores
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      iwait    <= 0;
      dwait    <= 0;
      st_count <= 0;
    end else begin
      iwait <= (imem_req && !imem_ack) ? iwait + 1 : 0;
      dwait <= (dmem_req && !dmem_ack) ? dwait + 1 : 0;
      if (dmem_req && dmem_ack && dmem_we) begin
        st_addr_log[st_count[2:0]] <= dmem_addr;
        st_data_log[st_count[2:0]] <= dmem_wdata;
        st_count <= st_count + 1;
      end
    end
  end

  function automatic logic [31:0] enc_r(logic [5:0] op, int rd, int rs, int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rt, int rs, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, int off);
    return {op, 26'(off)};
  endfunction

  task automatic clear_imem;
    for (int i = 0; i < 1024; i++) imem[i] = HALT_WORD;
  endtask

  task automatic reset_core;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_retire(input logic [31:0] target, output int cycles);
    cycles = 0;
    while (instret !== target && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic wait_halt;
    int k;
    k = 0;
    while (halted !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset;
    int c;
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 1, 0, 5);
    imem[1]  = enc_i(OP_ADDI, 2, 0, 7);
    imem[2]  = enc_r(OP_ADD, 3, 1, 2);
    imem[3]  = enc_i(OP_SW, 3, 0, 100);
    imem[4]  = enc_i(OP_ADDI, 1, 0, 4);
    imem[5]  = enc_i(OP_LW, 5, 1, 2);
    imem[6]  = enc_i(OP_SW, 5, 0, 101);
    imem[7]  = enc_i(OP_ADDI, 6, 0, 1023);
    imem[8]  = enc_i(OP_SW, 5, 6, 1);
    imem[9]  = enc_r(OP_MV, 7, 3, 0);
    imem[10] = enc_i(OP_SW, 7, 0, 102);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_req got=%b exp=0", imem_req); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_dmem got req=%b we=%b exp=0/0", dmem_req, dmem_we); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pc_out !== 32'd0 || instret !== 32'd0) begin failures++; $display("[TB] FAIL reset_pc_instret got pc=%0d instret=%0d exp=0/0", pc_out, instret); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin failures++; $display("[TB] FAIL first_fetch got req=%b addr=%0d exp=1/0", imem_req, imem_addr); end
    wait_retire(32'd1, c);
    checks++; if (c !== 4) begin failures++; $display("[TB] FAIL addi_latency got=%0d exp=4", c); end
    checks++; if (pc_out !== 32'd1) begin failures++; $display("[TB] FAIL addi_pc got=%0d exp=1", pc_out); end
  endtask

  task automatic test_alu_store;
    int c;
    wait_retire(32'd2, c);
    wait_retire(32'd3, c);
    checks++; if (c !== 4) begin failures++; $display("[TB] FAIL add_latency got=%0d exp=4", c); end
    checks++; if (pc_out !== 32'd3) begin failures++; $display("[TB] FAIL add_pc got=%0d exp=3", pc_out); end
    wait_retire(32'd4, c);
    checks++; if (c !== 4) begin failures++; $display("[TB] FAIL store_latency got=%0d exp=4", c); end
    checks++; if (st_count !== 1 || st_addr_log[0] !== 10'd100 || st_data_log[0] !== 32'd12) begin
      failures++; $display("[TB] FAIL add_result got n=%0d addr=%0d data=%0d exp=1/100/12", st_count, st_addr_log[0], st_data_log[0]);
    end
  endtask

  task automatic test_load_wait;
    int   c;
    logic saw_req, addr_ok;
    wait_retire(32'd5, c);
    dmem_lat = 3;
    c = 0; saw_req = 1'b0; addr_ok = 1'b1;
    while (instret !== 32'd6 && c < 300) begin
      if (dmem_req === 1'b1) begin
        saw_req = 1'b1;
        if (dmem_addr !== 10'd6 || dmem_we !== 1'b0) addr_ok = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    dmem_lat = 0;
    checks++; if (c !== 8) begin failures++; $display("[TB] FAIL load_latency got=%0d exp=8", c); end
    checks++; if (saw_req !== 1'b1 || addr_ok !== 1'b1) begin failures++; $display("[TB] FAIL load_addr_stable got seen=%b stable=%b exp=1/1", saw_req, addr_ok); end
    wait_retire(32'd7, c);
    checks++; if (st_addr_log[1] !== 10'd101 || st_data_log[1] !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL load_result got addr=%0d data=%h exp=101/deadbeef", st_addr_log[1], st_data_log[1]);
    end
  endtask

  task automatic test_store_wrap;
    int          c;
    logic [9:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_data;
    wait_retire(32'd8, c);
    c = 0; cap_addr = 10'h3FF; cap_we = 1'b0; cap_data = 32'd0;
    while (instret !== 32'd9 && c < 300) begin
      if (dmem_req === 1'b1) begin cap_addr = dmem_addr; cap_we = dmem_we; cap_data = dmem_wdata; end
      @(posedge clk); #1;
      c++;
    end
    checks++; if (cap_addr !== 10'd0) begin failures++; $display("[TB] FAIL wrap_addr got=%0d exp=0", cap_addr); end
    checks++; if (cap_we !== 1'b1) begin failures++; $display("[TB] FAIL wrap_we got=%b exp=1", cap_we); end
    checks++; if (cap_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wrap_wdata got=%h exp=deadbeef", cap_data); end
    wait_retire(32'd11, c);
    checks++; if (st_count !== 4 || st_addr_log[3] !== 10'd102 || st_data_log[3] !== 32'd12) begin
      failures++; $display("[TB] FAIL mv_result got n=%0d addr=%0d data=%0d exp=4/102/12", st_count, st_addr_log[3], st_data_log[3]);
    end
    wait_halt();
    checks++; if (halted !== 1'b1 || pc_out !== 32'd11) begin failures++; $display("[TB] FAIL prog1_halt got halted=%b pc=%0d exp=1/11", halted, pc_out); end
  endtask

  task automatic test_branch;
    int c;
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 1, 0, 3);
    imem[1]  = enc_i(OP_ADDI, 2, 0, 9);
    imem[2]  = enc_j(OP_JMP, 8);
    imem[10] = enc_i(OP_BNE, 2, 1, -4);
    imem[6]  = enc_i(OP_ADDI, 2, 0, 3);
    imem[7]  = enc_j(OP_JMP, 3);
    reset_core();
    wait_retire(32'd3, c);
    checks++; if (pc_out !== 32'd10) begin failures++; $display("[TB] FAIL jump_pc got=%0d exp=10", pc_out); end
    wait_retire(32'd4, c);
    checks++; if (c !== 3) begin failures++; $display("[TB] FAIL taken_latency got=%0d exp=3", c); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd6) begin failures++; $display("[TB] FAIL taken_target got req=%b addr=%0d exp=1/6", imem_req, imem_addr); end
    wait_retire(32'd5, c);
    wait_retire(32'd6, c);
    checks++; if (c !== 3 || pc_out !== 32'd10) begin failures++; $display("[TB] FAIL jump_back got cycles=%0d pc=%0d exp=3/10", c, pc_out); end
    wait_retire(32'd7, c);
    checks++; if (c !== 3) begin failures++; $display("[TB] FAIL untaken_latency got=%0d exp=3", c); end
    checks++; if (imem_addr !== 10'd11) begin failures++; $display("[TB] FAIL untaken_target got=%0d exp=11", imem_addr); end
    wait_halt();
    checks++; if (instret !== 32'd7 || pc_out !== 32'd11) begin failures++; $display("[TB] FAIL branch_halt got instret=%0d pc=%0d exp=7/11", instret, pc_out); end
  endtask

  task automatic test_halt;
    int   c;
    logic req_seen, unhalted;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 1, 0, 1);
    imem[1] = enc_i(OP_ADDI, 2, 0, 2);
    imem[2] = {6'h3E, 26'h155_5555};
    imem[4] = enc_i(OP_ADDI, 3, 0, 3);
    reset_core();
    wait_retire(32'd2, c);
    wait_retire(32'd3, c);
    checks++; if (c !== 3) begin failures++; $display("[TB] FAIL undef_nop_latency got=%0d exp=3", c); end
    wait_halt();
    checks++; if (halted !== 1'b1 || pc_out !== 32'd3) begin failures++; $display("[TB] FAIL halt_enter got halted=%b pc=%0d exp=1/3", halted, pc_out); end
    stray_iack = 1'b1;
    stray_dack = 1'b1;
    req_seen = 1'b0; unhalted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0) req_seen = 1'b1;
      if (halted !== 1'b1) unhalted = 1'b1;
    end
    stray_iack = 1'b0;
    stray_dack = 1'b0;
    checks++; if (req_seen !== 1'b0 || unhalted !== 1'b0) begin failures++; $display("[TB] FAIL halt_absorbing got req=%b left=%b exp=0/0", req_seen, unhalted); end
    checks++; if (instret !== 32'd3 || pc_out !== 32'd3) begin failures++; $display("[TB] FAIL halt_frozen got instret=%0d pc=%0d exp=3/3", instret, pc_out); end
  endtask

  task automatic test_reset_mid_request;
    int c;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 1, 0, 50);
    imem[1] = enc_i(OP_SW, 1, 1, 0);
    dmem_lat = 1000;
    reset_core();
    c = 0;
    while (dmem_req !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 10'd50) begin failures++; $display("[TB] FAIL pending_store got req=%b addr=%0d exp=1/50", dmem_req, dmem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_drops_req got dreq=%b we=%b ireq=%b exp=0/0/0", dmem_req, dmem_we, imem_req);
    end
    checks++; if (pc_out !== 32'd0 || instret !== 32'd0) begin failures++; $display("[TB] FAIL reset_mid_state got pc=%0d instret=%0d exp=0/0", pc_out, instret); end
    dmem_lat = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin failures++; $display("[TB] FAIL refetch got req=%b addr=%0d exp=1/0", imem_req, imem_addr); end
    wait_retire(32'd1, c);
    checks++; if (c !== 4) begin failures++; $display("[TB] FAIL refetch_latency got=%0d exp=4", c); end
    wait_halt();
    checks++; if (instret !== 32'd2 || st_count !== 1 || st_data_log[0] !== 32'd50) begin
      failures++; $display("[TB] FAIL rerun_store got instret=%0d n=%0d data=%0d exp=2/1/50", instret, st_count, st_data_log[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem_init[i] = 32'h0;
    dmem_init[6] = 32'hDEADBEEF;
    $display("[TB] start");
    test_reset();
    test_alu_store();
    test_load_wait();
    test_store_wrap();
    test_branch();
    test_halt();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
